// File: rtl/gf180mcu_pwrsw_pkg.sv
// Shared types and helpers for the row/column power-switch sequencers.
package gf180mcu_pwrsw_pkg;

  localparam int MAX_SEG = 32;

  typedef enum logic [2:0] {
    OFF,
    RAMP_UP,
    SETTLE,
    ON,
    RAMP_DN
  } state_t;

  function automatic int cnt_width(input int step, input int settle);
    int m;
    m = (step > settle) ? step : settle;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_therm.sv
// Thermometer shift register: grow fills from bit 0, shrink drops the top bit.
module gf180mcu_fd_sc_mcu7t5v0__pwrsw_therm
  import gf180mcu_pwrsw_pkg::*;
#(
  parameter int N_SEG = 4
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             grow,
  input  logic             shrink,
  input  logic             clear,
  output logic [N_SEG-1:0] q
);

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (grow) begin
      q <= (q << 1) | N_SEG'(1);
    end else if (shrink) begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.sv
// Row power-switch sequencer with staggered segment ramp and isolation.
// GF180MCU_PWRSW_SEQ_RET_EN adds SAVE/RESTORE retention handshakes.
module gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq
  import gf180mcu_pwrsw_pkg::*;
#(
  parameter int N_SEG         = 4,
  parameter int STEP_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             PWR_REQ,
  output logic [N_SEG-1:0] SW_EN,
  output logic             PWR_ACK,
  output logic             ISO,
  output logic             BUSY,
`ifdef GF180MCU_PWRSW_SEQ_RET_EN
  output logic             SAVE,
  output logic             RESTORE,
`endif
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int CW = cnt_width(STEP_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] STEP_LD = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] SETL_LD = CW'(SETTLE_CYCLES - 1);
`ifdef GF180MCU_PWRSW_SEQ_RET_EN
  localparam logic [CW-1:0] DN_LD = CW'(STEP_CYCLES);
`else
  localparam logic [CW-1:0] DN_LD = STEP_LD;
`endif

  wire unused_rails = VDD ^ VSS;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            grow, shrink;
  logic            tick, full_up, empty_dn;
  logic [N_SEG-1:0] grown;
  logic            save_n, restore_n;
`ifdef GF180MCU_PWRSW_SEQ_RET_EN
  logic            restore_q;
  assign restore_q = RESTORE;
`endif

  gf180mcu_fd_sc_mcu7t5v0__pwrsw_therm #(.N_SEG(N_SEG)) u_therm (
    .CLK    (CLK),
    .R      (R),
    .grow   (grow),
    .shrink (shrink),
    .clear  (1'b0),
    .q      (SW_EN)
  );

  assign grown    = (SW_EN << 1) | N_SEG'(1);
  assign full_up  = &grown;
  assign empty_dn = ((SW_EN >> 1) == '0);
  assign tick     = (cnt == '0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    grow      = 1'b0;
    shrink    = 1'b0;
    save_n    = 1'b0;
    restore_n = 1'b0;
    unique case (state)
      OFF: begin
        if (PWR_REQ) begin
          grow = 1'b1;
          if (full_up) begin
            state_n = SETTLE;
            cnt_n   = SETL_LD;
          end else begin
            state_n = RAMP_UP;
            cnt_n   = STEP_LD;
          end
        end
      end
      RAMP_UP: begin
        if (!PWR_REQ) begin
          state_n = RAMP_DN;
          cnt_n   = STEP_LD;
        end else if (tick) begin
          grow = 1'b1;
          if (full_up) begin
            state_n = SETTLE;
            cnt_n   = SETL_LD;
          end else begin
            cnt_n = STEP_LD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (!PWR_REQ) begin
          state_n = RAMP_DN;
          cnt_n   = STEP_LD;
        end else if (tick) begin
`ifdef GF180MCU_PWRSW_SEQ_RET_EN
          // Hold one extra cycle so RESTORE lands before isolation drops.
          if (restore_q) state_n = ON;
          else           restore_n = 1'b1;
`else
          state_n = ON;
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ON: begin
        if (!PWR_REQ) begin
          state_n = RAMP_DN;
          cnt_n   = DN_LD;
          save_n  = 1'b1;
        end
      end
      RAMP_DN: begin
        if (PWR_REQ) begin
          if (&SW_EN) begin
            state_n = SETTLE;
            cnt_n   = SETL_LD;
          end else begin
            state_n = RAMP_UP;
            cnt_n   = STEP_LD;
          end
        end else if (tick) begin
          shrink = 1'b1;
          if (empty_dn) begin
            state_n = OFF;
            cnt_n   = '0;
          end else begin
            cnt_n = STEP_LD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = OFF;
        cnt_n   = '0;
      end
    endcase
  end

  // Status flags are registered from the next state to stay glitch-free.
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state   <= OFF;
      cnt     <= '0;
      PWR_ACK <= 1'b0;
      ISO     <= 1'b1;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      PWR_ACK <= (state_n == ON);
      ISO     <= (state_n != ON);
      BUSY    <= (state_n inside {RAMP_UP, SETTLE, RAMP_DN});
    end
  end

`ifdef GF180MCU_PWRSW_SEQ_RET_EN
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      SAVE    <= 1'b0;
      RESTORE <= 1'b0;
    end else begin
      SAVE    <= save_n;
      RESTORE <= restore_n;
    end
  end
`else
  wire unused_ret = save_n ^ restore_n;
`endif

endmodule
